// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank pattern, the active-low glyph table
// for hex digits 0..F, capture FSM encoding and a glyph-to-hex helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit order g..a; entry i is the glyph for hex value i.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } cap_state_e;

  // Returns {hit, value}; hit is 0 when the pattern is not a hex glyph.
  function automatic logic [4:0] glyph_to_hex(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (SEG_GLYPHS[i] == pat) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational decode of an active-low segment pattern into a hex digit,
// with blank and illegal classification (mutually exclusive, digit=0 for both).
module seg7_glyph_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       illegal_o
);

  logic [4:0] hit_val_s;

  // Classify the pattern and extract the digit value.
  always_comb begin
    hit_val_s = glyph_to_hex(pat_i);
    digit_o   = 4'd0;
    blank_o   = 1'b0;
    illegal_o = 1'b0;
    if (pat_i == SEG_BLANK) begin
      blank_o = 1'b1;
    end else if (hit_val_s[4]) begin
      digit_o = hit_val_s[3:0];
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/seg7_pattern_capture.sv
// Recovers the hex value shown on a seven-segment bus: debounces the pattern,
// reports each new stable pattern once over valid/ready, flags overruns.
module seg7_pattern_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] digit,
  output logic       blank,
  output logic       illegal,
  output logic       overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       pat_s;
  logic             same_s, stable_s, report_s;
  logic [3:0]       lk_digit_s;
  logic             lk_blank_s, lk_illegal_s;

  logic [6:0]       samp_q, samp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       last_q, last_d;
  logic             have_last_q, have_last_d;
  cap_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic             illegal_q, illegal_d;
  logic             overrun_q, overrun_d;

  assign pat_s    = ACTIVE_LOW ? seg_in : ~seg_in;
  assign same_s   = (pat_s == samp_q);
  assign stable_s = same_s && (cnt_q == CNT_MAX);
  assign report_s = stable_s && (!have_last_q || (samp_q != last_q));

  seg7_glyph_lookup u_lookup (
    .pat_i     (samp_q),
    .digit_o   (lk_digit_s),
    .blank_o   (lk_blank_s),
    .illegal_o (lk_illegal_s)
  );

  // Stability tracking, report FSM and output field updates.
  always_comb begin
    samp_d      = pat_s;
    cnt_d       = cnt_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    state_d     = state_q;
    digit_d     = digit_q;
    blank_d     = blank_q;
    illegal_d   = illegal_q;
    overrun_d   = overrun_q;

    if (!same_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_WAIT: begin
        if (report_s) begin
          digit_d     = lk_digit_s;
          blank_d     = lk_blank_s;
          illegal_d   = lk_illegal_s;
          last_d      = samp_q;
          have_last_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        // A new pattern while a result is pending is dropped, not remembered.
        if (report_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (out_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    out_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q      <= SEG_BLANK;
      cnt_q       <= '0;
      last_q      <= SEG_BLANK;
      have_last_q <= 1'b0;
      state_q     <= ST_WAIT;
      out_valid_q <= 1'b0;
      digit_q     <= 4'd0;
      blank_q     <= 1'b0;
      illegal_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      digit_q     <= digit_d;
      blank_q     <= blank_d;
      illegal_q   <= illegal_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign digit     = digit_q;
  assign blank     = blank_q;
  assign illegal   = illegal_q;
  assign overrun   = overrun_q;

endmodule
